// File: rtl/res_readout_pkg.sv
// Shared types and size helpers for the res_readout result window.
// Shared by res_readout and res_word_mux.
package res_readout_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bank_state_e;

    function automatic int calc_word_bytes(input int width, input int bits);
        return width * bits / 8;
    endfunction

    function automatic int calc_win_bytes(input int n, input int bits);
        return n * n * bits / 8;
    endfunction

    function automatic int calc_words(input int n, input int width);
        return n * n / width;
    endfunction

    // Right-shift that turns a byte offset into a word index.
    function automatic int addr_shift(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/res_word_mux.sv
// Combinational word select: returns word idx of a flattened bank.
module res_word_mux
    import res_readout_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int WIDTH = 4,
    parameter int WORDS = 16,
    parameter int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [WORDS*WIDTH*BITS-1:0] bank,
    input  logic [IDX_W-1:0]            idx,
    output logic [WIDTH*BITS-1:0]       word
);

    localparam int WW = WIDTH * BITS;

    always_comb begin
        word = '0;
        for (int j = 0; j < WORDS; j++) begin
            if (idx == IDX_W'(j)) begin
                word = bank[j*WW +: WW];
            end
        end
    end

endmodule

// File: rtl/res_readout.sv
// Double-buffered, memory-mapped readout window for matrix-multiply results.
// Optional feature: define RES_READOUT_STATUS_EN to map a status word just past the window.
module res_readout
    import res_readout_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int N          = 8,
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int OFFSET     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [N*N*BITS-1:0]   all,
    input  logic                  consume,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH*BITS-1:0] rdata,
    output logic                  rvalid,
    output logic                  hit,
    output logic                  avail,
    output logic                  overflow
);

    localparam int WORD_BYTES = calc_word_bytes(WIDTH, BITS);
    localparam int WIN_BYTES  = calc_win_bytes(N, BITS);
    localparam int WORDS      = calc_words(N, WIDTH);
    localparam int SHIFT      = addr_shift(WORD_BYTES);
    localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RW         = WIDTH * BITS;
    localparam int MW         = N * N * BITS;

    bank_state_e     state_q, state_d;
    logic            wp_q, wp_d;
    logic            rp_q, rp_d;
    logic            overflow_q, overflow_d;
    logic            do_load, do_consume, ovf_set;

    logic [MW-1:0]   bank0_q, bank0_d;
    logic [MW-1:0]   bank1_q, bank1_d;

    logic            rvalid_q, rvalid_d;
    logic            hit_q, hit_d;
    logic [RW-1:0]   rdata_q, rdata_d;

    logic [31:0]     off_w;
    logic            in_win;
    logic [IDX_W-1:0] word_idx;
    logic [RW-1:0]   word;
`ifdef RES_READOUT_STATUS_EN
    logic            is_status;
`endif

    // Bank state register plus sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            overflow_q <= overflow_d;
        end
    end

    // At FULL a same-cycle consume frees a bank first, so the load is accepted.
    always_comb begin
        do_consume = consume && (state_q != EMPTY);
        do_load    = load && ((state_q != FULL) || consume);
        ovf_set    = load && (state_q == FULL) && !consume;
        state_d    = state_q;
        case ({do_load, do_consume})
            2'b10:   state_d = (state_q == EMPTY) ? ONE : FULL;
            2'b01:   state_d = (state_q == FULL) ? ONE : EMPTY;
            default: state_d = state_q;
        endcase
        wp_d       = wp_q ^ do_load;
        rp_d       = rp_q ^ do_consume;
        overflow_d = overflow_q | ovf_set;
    end

    always_comb begin
        avail    = (state_q != EMPTY);
        overflow = overflow_q;
        rvalid   = rvalid_q;
        hit      = hit_q;
        rdata    = rdata_q;
    end

    // Shadow banks hold data only; reset leaves them untouched.
    always_comb begin
        bank0_d = bank0_q;
        bank1_d = bank1_q;
        if (do_load && !wp_q) bank0_d = all;
        if (do_load &&  wp_q) bank1_d = all;
    end

    always_ff @(posedge clk) begin
        bank0_q <= bank0_d;
        bank1_q <= bank1_d;
    end

    // Addresses below OFFSET wrap to a huge offset, so one compare bounds both sides.
    always_comb begin
        off_w    = 32'(addr) - 32'(OFFSET);
        in_win   = off_w < 32'(WIN_BYTES);
        word_idx = IDX_W'(off_w >> SHIFT);
`ifdef RES_READOUT_STATUS_EN
        is_status = (off_w == 32'(WIN_BYTES));
`endif
    end

    res_word_mux #(
        .BITS  (BITS),
        .WIDTH (WIDTH),
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_word_mux (
        .bank (rp_q ? bank1_q : bank0_q),
        .idx  (word_idx),
        .word (word)
    );

    // Read stage: uses pre-consume rp_q, so a same-cycle consume still sees the old bank.
    always_comb begin
        rvalid_d = rd_en;
        hit_d    = 1'b0;
        rdata_d  = '0;
        if (rd_en) begin
            if (in_win) begin
                hit_d = 1'b1;
                if (state_q != EMPTY) rdata_d = word;
            end
`ifdef RES_READOUT_STATUS_EN
            else if (is_status) begin
                hit_d   = 1'b1;
                rdata_d = RW'({overflow_q, 2'(state_q)});
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            hit_q    <= hit_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_res_readout.sv
// Directed bench for res_readout (N=4, BITS=8, WIDTH=4, OFFSET=0x100).
module tb_res_readout;

    localparam int BITS = 8;
    localparam int N = 4;
    localparam int WIDTH = 4;
    localparam int ADDR_WIDTH = 10;
    localparam int OFFSET = 'h100;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  load = 1'b0;
    logic [N*N*BITS-1:0]   all = '0;
    logic                  consume = 1'b0;
    logic                  rd_en = 1'b0;
    logic [ADDR_WIDTH-1:0] addr = '0;
    logic [WIDTH*BITS-1:0] rdata;
    logic                  rvalid;
    logic                  hit;
    logic                  avail;
    logic                  overflow;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [ADDR_WIDTH-1:0] a;
        logic                  exp_hit;
        logic [31:0]           exp_data;
    } rd_vec_t;

    rd_vec_t vecs[10];

    res_readout #(
        .BITS(BITS), .N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .OFFSET(OFFSET)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .all(all), .consume(consume),
        .rd_en(rd_en), .addr(addr), .rdata(rdata), .rvalid(rvalid),
        .hit(hit), .avail(avail), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [N*N*BITS-1:0] pattern(input int base);
        logic [N*N*BITS-1:0] v;
        for (int k = 0; k < N*N; k++) v[8*k +: 8] = 8'(k + base);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_load(input int base);
        all  = pattern(base);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_consume();
        consume = 1'b1;
        tick();
        consume = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [ADDR_WIDTH-1:0] a,
                            input logic eh, input logic [31:0] ed);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
        check({name, ".rvalid"}, 32'(rvalid), 32'd1);
        check({name, ".hit"}, 32'(hit), 32'(eh));
        check({name, ".rdata"}, rdata, ed);
    endtask

    initial begin
        vecs[0] = '{10'h100, 1'b1, 32'h03020100};
        vecs[1] = '{10'h104, 1'b1, 32'h07060504};
        vecs[2] = '{10'h107, 1'b1, 32'h07060504};
        vecs[3] = '{10'h108, 1'b1, 32'h0B0A0908};
        vecs[4] = '{10'h10C, 1'b1, 32'h0F0E0D0C};
        vecs[5] = '{10'h10F, 1'b1, 32'h0F0E0D0C};
`ifdef RES_READOUT_STATUS_EN
        vecs[6] = '{10'h110, 1'b1, 32'h00000001};
`else
        vecs[6] = '{10'h110, 1'b0, 32'h00000000};
`endif
        vecs[7] = '{10'h0FF, 1'b0, 32'h00000000};
        vecs[8] = '{10'h000, 1'b0, 32'h00000000};
        vecs[9] = '{10'h3FF, 1'b0, 32'h00000000};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst.rvalid", 32'(rvalid), 32'd0);
        check("rst.hit", 32'(hit), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.avail", 32'(avail), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // 1: read while empty
        read_chk("t1.empty", 10'h100, 1'b1, 32'h0);
        check("t1.avail", 32'(avail), 32'd0);
        tick();
        check("t1.rvalid_drop", 32'(rvalid), 32'd0);
        check("t1.rdata_drop", rdata, 32'd0);

        // 2: load A and sweep the window
        do_load(0);
        check("t2.avail", 32'(avail), 32'd1);
        for (int i = 0; i < 10; i++) begin
            read_chk($sformatf("t2.vec%0d", i), vecs[i].a, vecs[i].exp_hit, vecs[i].exp_data);
        end

        // 3: fill, overflow, drain one
        do_load('h10);
        check("t3.ovf_before", 32'(overflow), 32'd0);
        do_load('h20);
        check("t3.overflow", 32'(overflow), 32'd1);
        check("t3.avail", 32'(avail), 32'd1);
`ifdef RES_READOUT_STATUS_EN
        read_chk("t6.status", 10'h110, 1'b1, 32'h6);
`else
        read_chk("t6.nostatus", 10'h110, 1'b0, 32'h0);
`endif
        read_chk("t3.bankA", 10'h100, 1'b1, 32'h03020100);
        do_consume();
        read_chk("t3.bankB", 10'h100, 1'b1, 32'h13121110);
        check("t3.ovf_sticky", 32'(overflow), 32'd1);

        // Reset during a read suppresses its rvalid
        rd_en = 1'b1;
        addr  = 10'h100;
        rst   = 1'b1;
        tick();
        rd_en = 1'b0;
        rst   = 1'b0;
        check("rst_mid.rvalid", 32'(rvalid), 32'd0);
        check("rst_mid.overflow", 32'(overflow), 32'd0);
        check("rst_mid.avail", 32'(avail), 32'd0);

        // 4: load+consume at FULL, with a same-cycle read
        do_load(0);
        do_load('h10);
        all     = pattern('h20);
        load    = 1'b1;
        consume = 1'b1;
        rd_en   = 1'b1;
        addr    = 10'h100;
        tick();
        load = 1'b0; consume = 1'b0; rd_en = 1'b0;
        check("t4.preconsume", rdata, 32'h03020100);
        check("t4.overflow", 32'(overflow), 32'd0);
        read_chk("t4.bankB", 10'h100, 1'b1, 32'h13121110);
        do_consume();
        read_chk("t4.bankC", 10'h100, 1'b1, 32'h23222120);
        check("t4.ovf_final", 32'(overflow), 32'd0);

        // 5: read with consume at ONE, then consume while empty
        consume = 1'b1;
        rd_en   = 1'b1;
        addr    = 10'h108;
        tick();
        consume = 1'b0; rd_en = 1'b0;
        check("t5.old_bank", rdata, 32'h2B2A2928);
        check("t5.avail0", 32'(avail), 32'd0);
        do_consume();
        check("t5.empty_consume", 32'(avail), 32'd0);
        read_chk("t5.empty_read", 10'h100, 1'b1, 32'h0);

        // Load+consume at ONE keeps one bank, the newer one
        do_load(0);
        all     = pattern('h10);
        load    = 1'b1;
        consume = 1'b1;
        tick();
        load = 1'b0; consume = 1'b0;
        check("t5.one_avail", 32'(avail), 32'd1);
        read_chk("t5.one_new", 10'h104, 1'b1, 32'h17161514);
`ifdef RES_READOUT_STATUS_EN
        read_chk("t5.one_status", 10'h110, 1'b1, 32'h1);
`endif
        do_consume();
        check("t5.one_drained", 32'(avail), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
